upsample_interp: RTL and testbench
==================================

UPSAMPLE_INTERP -- requirements
Module: upsample_interp

Interface
REQ-001 SHALL have port clock, input, 1 bit: master clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: master reset, asynchronous, active-high.
REQ-003 SHALL have port Nfreq, input, 4 bits: interpolation factor N. Values 0 and 1 both mean N=1.
REQ-004 SHALL have port datain, input, 18 bits: signed two's-complement input sample at Fs/N.
REQ-005 SHALL have port endatain, input, 1 bit: one-cycle input strobe at Fs/N.
REQ-006 SHALL have port en48k, input, 1 bit: one-cycle output-rate strobe, Fs=48kHz, spaced at least 32 clocks apart.
REQ-007 SHALL have port dataout, output, 18 bits: signed interpolated output sample, registered.
REQ-008 SHALL have port endataout, output, 1 bit: one-cycle output strobe at Fs.
REQ-009 SHALL have port overrun, output, 1 bit: sticky flag for an input strobe dropped while busy.

Function
REQ-010 SHALL hold x_old (18b, the previous sample) and x_new (18b, the latest sample).
REQ-011 SHALL hold a 27b signed accumulator acc (8 fractional bits) and a 27b signed step.
REQ-012 SHALL implement FSM states IDLE, DIV and RUN.
REQ-013 SHALL take the following actions on endatain in IDLE or RUN:
- x_old<=x_new; x_new<=datain.
- Latch N from Nfreq; phase counter k<=0.
- Go to DIV.
REQ-014 SHALL compute in DIV: delta = x_new - x_old, as a 19b signed value.
REQ-015 SHALL compute step = (delta*256)/N, truncated toward zero.
REQ-016 SHALL compute step with a sequential restoring divider on |delta*256| followed by sign restore.
REQ-017 SHALL take exactly 27 clocks in DIV, then set acc<=x_old*256 and go to RUN.
REQ-018 SHALL, when N=1, skip the divider: step<=0, acc<=x_new*256, go to RUN on the next clock.
REQ-019 SHALL, on an en48k tick in RUN with k<N, output dataout<=acc>>>8 (arithmetic shift, floor) and update acc<=acc+step, k<=k+1.
REQ-020 SHALL, on an en48k tick in RUN with k>=N, output dataout<=x_new (hold endpoint).
REQ-021 SHALL, on an en48k tick in IDLE or DIV, leave dataout unchanged (repeat last value).
REQ-022 SHALL assert endataout for exactly one clock, on the clock after every en48k tick, in all states.
REQ-023 SHALL ignore endatain while in DIV: sample dropped, overrun<=1, overrun stays 1 until reset.
REQ-024 SHALL, when endatain and en48k coincide in RUN, first service the tick with old state and then start the new sample as in REQ-013.
REQ-025 SHALL ignore Nfreq changes between input strobes; the new N applies only from the next endatain.
REQ-026 SHALL keep every output between x_old and x_new inclusive, with no saturation logic needed.
REQ-027 SHALL have a latency of one input period: output tracks the segment from x_old to x_new.

Reset
REQ-028 SHALL, on asynchronous reset, immediately clear to 0 dataout, endataout, overrun, x_old, x_new, acc, step and k, and set the FSM to IDLE.
REQ-029 SHALL, on reset asserted mid-DIV or mid-RUN, abort and discard all partial results.
REQ-030 SHALL, after reset release, have first endatain behave as REQ-013 with x_old=0.

Verification
REQ-031 SHALL cover: N=4, inputs 0 then 400, four en48k ticks after DIV -> dataout 0,100,200,300 with step=25600.
REQ-032 SHALL cover: N=3, inputs 0 then -300 -> step=-25600, dataout 0,-100,-200; a fourth tick with no new input -> dataout -300.
REQ-033 SHALL cover: Nfreq=0 and Nfreq=1, datain 5000 -> dataout 5000 on the next tick, divider skipped (DIV lasts 1 clock).
REQ-034 SHALL cover: second endatain 10 clocks after the first (during DIV) -> overrun=1, second sample discarded, first segment output intact.
REQ-035 SHALL cover: N=5, inputs 0 then 7, five ticks -> dataout 0,1,2,4,5 (step=358, floor of acc>>>8).
REQ-036 SHALL cover: reset asserted asynchronously mid-DIV -> dataout=0, endataout=0, overrun=0 without a clock edge; normal operation on the next endatain.

Source files
------------

// File: rtl/upsample_interp.sv
// Linear-interpolating upsampler: one input sample per N output ticks, ramping from the
// previous sample to the latest one with a fixed-point step from a serial divider.
module upsample_interp (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         Nfreq,
  input  logic signed [17:0] datain,
  input  logic               endatain,
  input  logic               en48k,
  output logic signed [17:0] dataout,
  output logic               endataout,
  output logic               overrun
);

  typedef enum logic [1:0] {StIdle, StDiv, StRun} state_e;

  state_e             state_q;
  logic signed [17:0] x_old_q, x_new_q;
  logic signed [26:0] acc_q, step_q;
  logic [3:0]         n_q, k_q;
  logic [4:0]         cnt_q, rem_q;
  logic [26:0]        quo_q;

  logic signed [18:0] delta;
  logic [18:0]        delta_mag;
  logic [26:0]        dividend;
  logic [4:0]         bit_idx, rem_sh, rem_nx;
  logic               ge;
  logic [26:0]        quo_nx;
  logic signed [26:0] step_div, x_old_ext, x_new_ext;
  logic [3:0]         n_in;
  logic               start;

  assign delta     = {x_new_q[17], x_new_q} - {x_old_q[17], x_old_q};
  assign delta_mag = delta[18] ? 19'(-delta) : 19'(delta);
  assign dividend  = {delta_mag, 8'd0};

  // Restoring divider: one quotient bit per clock, MSB of |delta*256| first.
  assign bit_idx  = 5'd26 - cnt_q;
  assign rem_sh   = {rem_q[3:0], dividend[bit_idx]};
  assign ge       = rem_sh >= {1'b0, n_q};
  assign rem_nx   = ge ? rem_sh - {1'b0, n_q} : rem_sh;
  assign quo_nx   = {quo_q[25:0], ge};
  assign step_div = delta[18] ? -$signed(quo_nx) : $signed(quo_nx);

  assign x_old_ext = $signed({x_old_q[17], x_old_q, 8'd0});
  assign x_new_ext = $signed({x_new_q[17], x_new_q, 8'd0});
  assign n_in      = (Nfreq < 4'd2) ? 4'd1 : Nfreq;
  assign start     = endatain && (state_q != StDiv);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      x_old_q   <= '0;
      x_new_q   <= '0;
      acc_q     <= '0;
      step_q    <= '0;
      n_q       <= 4'd1;
      k_q       <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dataout   <= '0;
      endataout <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      endataout <= en48k;
      unique case (state_q)
        StIdle: ;
        StDiv: begin
          if (endatain) overrun <= 1'b1;
          if (n_q == 4'd1) begin
            step_q  <= '0;
            acc_q   <= x_new_ext;
            state_q <= StRun;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd26) begin
              step_q  <= step_div;
              acc_q   <= x_old_ext;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (en48k) begin
            if (k_q < n_q) begin
              dataout <= acc_q[25:8];
              acc_q   <= acc_q + step_q;
              k_q     <= k_q + 4'd1;
            end else begin
              dataout <= x_new_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      // A coincident tick in RUN was already served above from the old state.
      if (start) begin
        x_old_q <= x_new_q;
        x_new_q <= datain;
        n_q     <= n_in;
        k_q     <= '0;
        cnt_q   <= '0;
        rem_q   <= '0;
        quo_q   <= '0;
        state_q <= StDiv;
      end
    end
  end

endmodule

// File: tb/tb_upsample_interp.sv
// Self-checking bench for upsample_interp: expected output samples are queued per scenario
// and popped as each output strobe is observed.
module tb_upsample_interp;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [3:0]         Nfreq = 4'd0;
  logic signed [17:0] datain = '0;
  logic               endatain = 1'b0;
  logic               en48k = 1'b0;
  logic signed [17:0] dataout;
  logic               endataout;
  logic               overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic signed [17:0] exp_q[$];
  logic signed [17:0] exp_v;

  upsample_interp dut (
    .clock    (clock),
    .reset    (reset),
    .Nfreq    (Nfreq),
    .datain   (datain),
    .endatain (endatain),
    .en48k    (en48k),
    .dataout  (dataout),
    .endataout(endataout),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic send(input logic signed [17:0] d, input logic [3:0] n);
    @(negedge clock);
    datain = d; Nfreq = n; endatain = 1'b1;
    @(negedge clock);
    endatain = 1'b0;
  endtask

  task automatic tick();
    @(negedge clock);
    en48k = 1'b1;
    @(negedge clock);
    en48k = 1'b0;
  endtask

  task automatic settle();
    repeat (30) @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (dataout !== 18'sd0) begin n_fail++; $display("FAIL reset_dataout: got %0d want 0", dataout); end
    n_checks++; if (endataout !== 1'b0) begin n_fail++; $display("FAIL reset_endataout: got %b want 0", endataout); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (endataout !== 1'b0) begin n_fail++; $display("FAIL idle_no_strobe: got %b want 0", endataout); end
  endtask

  task automatic test_interp_n4();
    send(18'sd0, 4'd4); settle();
    send(18'sd400, 4'd4); settle();
    n_checks++; if (dut.step_q !== 27'sd25600) begin n_fail++; $display("FAIL n4_step: got %0d want 25600", dut.step_q); end
    exp_q.push_back(18'sd0); exp_q.push_back(18'sd100); exp_q.push_back(18'sd200);
    exp_q.push_back(18'sd300); exp_q.push_back(18'sd400);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++; if (endataout !== 1'b1) begin n_fail++; $display("FAIL n4_strobe%0d: got %b want 1", i, endataout); end
      n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL n4_tick%0d: got %0d want %0d", i, dataout, exp_v); end
      @(negedge clock);
      n_checks++; if (endataout !== 1'b0) begin n_fail++; $display("FAIL n4_strobe_len%0d: got %b want 0", i, endataout); end
      repeat (31) @(negedge clock);
    end
  endtask

  task automatic test_interp_n3_neg();
    send(18'sd0, 4'd3); settle();
    send(-18'sd300, 4'd3); settle();
    n_checks++; if (dut.step_q !== -27'sd25600) begin n_fail++; $display("FAIL n3_step: got %0d want -25600", dut.step_q); end
    exp_q.push_back(18'sd0); exp_q.push_back(-18'sd100); exp_q.push_back(-18'sd200);
    exp_q.push_back(-18'sd300);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL n3_tick%0d: got %0d want %0d", i, dataout, exp_v); end
      repeat (32) @(negedge clock);
    end
  endtask

  task automatic test_n_one();
    // DIV must last a single clock: the tick lands on the second clock after the strobe.
    send(18'sd5000, 4'd0);
    exp_q.push_back(18'sd5000);
    tick();
    exp_v = exp_q.pop_front();
    n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL n0_tick: got %0d want %0d", dataout, exp_v); end
    repeat (32) @(negedge clock);
    send(18'sd1234, 4'd1);
    exp_q.push_back(18'sd1234); exp_q.push_back(18'sd1234);
    for (int i = 0; i < 2; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL n1_tick%0d: got %0d want %0d", i, dataout, exp_v); end
      repeat (32) @(negedge clock);
    end
  endtask

  task automatic test_overrun();
    send(18'sd0, 4'd4); settle();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: got %b want 0", overrun); end
    send(18'sd800, 4'd4);
    repeat (8) @(negedge clock);
    send(18'sd9999, 4'd4);
    settle();
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
    exp_q.push_back(18'sd0); exp_q.push_back(18'sd200); exp_q.push_back(18'sd400);
    exp_q.push_back(18'sd600); exp_q.push_back(18'sd800);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL overrun_tick%0d: got %0d want %0d", i, dataout, exp_v); end
      repeat (32) @(negedge clock);
    end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_floor_n5();
    send(18'sd0, 4'd5); settle();
    send(18'sd7, 4'd5); settle();
    exp_q.push_back(18'sd0); exp_q.push_back(18'sd1); exp_q.push_back(18'sd2);
    exp_q.push_back(18'sd4); exp_q.push_back(18'sd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL n5_tick%0d: got %0d want %0d", i, dataout, exp_v); end
      repeat (32) @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    // Tick and new sample together: tick served from the finished 0..7 segment (k==N).
    @(negedge clock);
    en48k = 1'b1; endatain = 1'b1; datain = 18'sd100; Nfreq = 4'd2;
    exp_q.push_back(18'sd7);
    @(negedge clock);
    en48k = 1'b0; endatain = 1'b0;
    exp_v = exp_q.pop_front();
    n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL coincide_tick: got %0d want %0d", dataout, exp_v); end
    settle();
    exp_q.push_back(18'sd7); exp_q.push_back(18'sd53); exp_q.push_back(18'sd100);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL coincide_seg%0d: got %0d want %0d", i, dataout, exp_v); end
      repeat (32) @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_div();
    send(18'sd500, 4'd4);
    repeat (3) @(negedge clock);
    tick();
    n_checks++; if (endataout !== 1'b1) begin n_fail++; $display("FAIL div_tick_strobe: got %b want 1", endataout); end
    n_checks++; if (dataout !== 18'sd100) begin n_fail++; $display("FAIL div_tick_hold: got %0d want 100", dataout); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (dataout !== 18'sd0) begin n_fail++; $display("FAIL async_dataout: got %0d want 0", dataout); end
    n_checks++; if (endataout !== 1'b0) begin n_fail++; $display("FAIL async_endataout: got %b want 0", endataout); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL async_overrun: got %b want 0", overrun); end
    @(negedge clock);
    reset = 1'b0;
    send(18'sd300, 4'd3); settle();
    exp_q.push_back(18'sd0); exp_q.push_back(18'sd100); exp_q.push_back(18'sd200);
    exp_q.push_back(18'sd300);
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_checks++; if (dataout !== exp_v) begin n_fail++; $display("FAIL post_reset_tick%0d: got %0d want %0d", i, dataout, exp_v); end
      repeat (32) @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_interp_n4();
    test_interp_n3_neg();
    test_n_one();
    test_overrun();
    test_floor_n5();
    test_back_to_back();
    test_reset_mid_div();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
